// File: rtl/imem_load_controller.sv
// imem_load_controller
// Arbitrates a single-port word-addressed instruction memory between the CPU
// fetch path and a streaming program loader. A load stalls the CPU, writes
// load_len words starting at load_base (wrapping at the top of memory), spends
// one FLUSH cycle, then returns to RUN with a one-cycle load_done pulse.
module imem_load_controller #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              cpu_stall,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_misaligned,
  output logic              fetch_oor,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t              state_reg;
  state_t              state_next;

  logic [ADDR_W-1:0]   base_reg;
  logic [ADDR_W:0]     len_reg;
  logic [ADDR_W:0]     count_reg;
  logic [ADDR_W:0]     count_inc;

  logic                fetch_valid_reg;
  logic [DATA_W-1:0]   fetch_data_reg;
  logic                misaligned_reg;
  logic                oor_reg;
  logic                load_done_reg;

  logic                accept;
  logic                last_word;
  logic                start_ok;
  logic                addr_oor;
  logic                addr_misaligned;

  // A word is accepted whenever the loader presents one while in LOAD.
  assign accept          = (state_reg == LOAD) && ld_valid;
  assign count_inc       = count_reg + CNT_ONE;
  // Completion is judged on the post-increment count so the handshake that
  // carries word load_len-1 is the one that ends the load.
  assign last_word       = (count_inc == len_reg);
  // A zero-length load is a no-op: no LOAD, no FLUSH, no load_done.
  assign start_ok        = load_start && (load_len != '0);
  assign addr_oor        = |fetch_addr[31:ADDR_W+2];
  assign addr_misaligned = |fetch_addr[1:0];

  // The read port simply follows the PC; out-of-range addresses alias here
  // but their data is suppressed when the response is registered.
  assign mem_raddr = fetch_addr[ADDR_W+1:2];

  assign fetch_valid      = fetch_valid_reg;
  assign fetch_data       = fetch_data_reg;
  assign fetch_misaligned = misaligned_reg;
  assign fetch_oor        = oor_reg;
  assign load_done        = load_done_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: RUN -> LOAD on a non-empty start, LOAD -> FLUSH on the
  // final accepted word, FLUSH always lasts exactly one cycle.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      RUN:     if (start_ok) state_next = LOAD;
      LOAD:    if (accept && last_word) state_next = FLUSH;
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Output logic: handshake, stall/busy and the combinational write port.
  always_comb begin
    ld_ready  = 1'b0;
    load_busy = 1'b0;
    cpu_stall = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    unique case (state_reg)
      LOAD: begin
        ld_ready  = 1'b1;
        load_busy = 1'b1;
        cpu_stall = 1'b1;
        // Address add truncates to ADDR_W bits so a load wraps past the top.
        mem_waddr = base_reg + count_reg[ADDR_W-1:0];
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_wdata = ld_data;
        end
      end
      FLUSH: begin
        load_busy = 1'b1;
        cpu_stall = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Load bookkeeping: latch base/length on start, advance the word counter
  // on each accepted word, and pulse load_done on the FLUSH -> RUN step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_reg      <= '0;
      len_reg       <= '0;
      count_reg     <= '0;
      load_done_reg <= 1'b0;
    end else begin
      load_done_reg <= (state_reg == FLUSH);
      if ((state_reg == RUN) && start_ok) begin
        base_reg  <= load_base;
        len_reg   <= load_len;
        count_reg <= '0;
      end else if (accept) begin
        count_reg <= count_inc;
      end
    end
  end

  // Fetch response register: only serviced in RUN; data is zeroed for
  // out-of-range PCs and held when no fetch is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid_reg <= 1'b0;
      fetch_data_reg  <= '0;
      misaligned_reg  <= 1'b0;
      oor_reg         <= 1'b0;
    end else if ((state_reg == RUN) && fetch_req) begin
      fetch_valid_reg <= 1'b1;
      fetch_data_reg  <= addr_oor ? '0 : mem_rdata;
      misaligned_reg  <= addr_misaligned;
      oor_reg         <= addr_oor;
    end else begin
      fetch_valid_reg <= 1'b0;
      misaligned_reg  <= 1'b0;
      oor_reg         <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_load_controller.sv
// Directed testbench for imem_load_controller with a behavioural 1024x32
// instruction memory attached to the controller's memory port.
module tb_imem_load_controller;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [ADDR_W:0]   load_len;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              load_busy;
  logic              load_done;
  logic              cpu_stall;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_misaligned;
  logic              fetch_oor;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] mem_model [0:(1<<ADDR_W)-1];

  int n_compared;
  int n_mismatched;

  imem_load_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .load_start       (load_start),
    .load_base        (load_base),
    .load_len         (load_len),
    .ld_valid         (ld_valid),
    .ld_data          (ld_data),
    .ld_ready         (ld_ready),
    .load_busy        (load_busy),
    .load_done        (load_done),
    .cpu_stall        (cpu_stall),
    .fetch_req        (fetch_req),
    .fetch_addr       (fetch_addr),
    .fetch_valid      (fetch_valid),
    .fetch_data       (fetch_data),
    .fetch_misaligned (fetch_misaligned),
    .fetch_oor        (fetch_oor),
    .mem_we           (mem_we),
    .mem_waddr        (mem_waddr),
    .mem_wdata        (mem_wdata),
    .mem_raddr        (mem_raddr),
    .mem_rdata        (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: synchronous write, combinational read.
  always @(posedge clk) if (mem_we) mem_model[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem_model[mem_raddr];

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem_model[i] = init_word(i);
    rst_n = 1'b0; load_start = 1'b0; load_base = '0; load_len = '0;
    ld_valid = 1'b0; ld_data = '0; fetch_req = 1'b0; fetch_addr = '0;

    // ---------------- reset state ----------------
    @(negedge clk); @(negedge clk); #1;
    check_value("rst_ready", ld_ready, 0);
    check_value("rst_busy", load_busy, 0);
    check_value("rst_done", load_done, 0);
    check_value("rst_stall", cpu_stall, 0);
    check_value("rst_fvalid", fetch_valid, 0);
    check_value("rst_fdata", fetch_data, 0);
    check_value("rst_we", mem_we, 0);
    check_value("rst_waddr", mem_waddr, 0);
    check_value("rst_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    $display("reset: outputs idle");

    // ---------------- basic load base=0x010 len=4 ----------------
    @(negedge clk); load_start = 1'b1; load_base = 10'h010; load_len = 11'd4; #1;
    check_value("t1_ready_in_run", ld_ready, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); load_start = 1'b0; ld_valid = 1'b1; ld_data = 32'hA0 + k; #1;
      check_value("t1_we", mem_we, 1);
      check_value("t1_waddr", mem_waddr, 32'h010 + k);
      check_value("t1_wdata", mem_wdata, 32'hA0 + k);
      check_value("t1_stall", cpu_stall, 1);
      check_value("t1_done", load_done, 0);
    end
    @(negedge clk); ld_data = 32'hA4; #1;
    check_value("t1_flush_ready", ld_ready, 0);
    check_value("t1_flush_we", mem_we, 0);
    check_value("t1_flush_stall", cpu_stall, 1);
    check_value("t1_flush_busy", load_busy, 1);
    check_value("t1_flush_done", load_done, 0);
    @(negedge clk); ld_valid = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h44; #1;
    check_value("t1_done_pulse", load_done, 1);
    check_value("t1_stall_off", cpu_stall, 0);
    check_value("t1_busy_off", load_busy, 0);
    @(negedge clk); fetch_req = 1'b0; #1;
    check_value("t1_fvalid", fetch_valid, 1);
    check_value("t1_fdata", fetch_data, 32'hA1);
    check_value("t1_done_once", load_done, 0);
    check_value("t1_mis", fetch_misaligned, 0);
    check_value("t1_oor", fetch_oor, 0);
    @(negedge clk); #1;
    check_value("t1_fvalid_off", fetch_valid, 0);
    check_value("t1_fdata_hold", fetch_data, 32'hA1);
    check_value("t1_mem13", mem_model[10'h013], 32'hA3);
    $display("load base=0x010 len=4 done, fetch 0x44 -> 0x%0h", fetch_data);

    // ---------------- wrapping load with gaps ----------------
    begin
      int k;
      k = 0;
      @(negedge clk); load_start = 1'b1; load_base = 10'h3FE; load_len = 11'd4; #1;
      for (int cyc = 0; cyc < 7; cyc++) begin
        @(negedge clk); load_start = 1'b0; ld_valid = (cyc % 2 == 0); ld_data = 32'hB0 + k; #1;
        check_value("t2_we", mem_we, ld_valid);
        check_value("t2_ready", ld_ready, 1);
        if (ld_valid) begin
          check_value("t2_waddr", mem_waddr, (32'h3FE + k) & 32'h3FF);
          k++;
        end
      end
    end
    @(negedge clk); ld_valid = 1'b0; #1;
    check_value("t2_flush_busy", load_busy, 1);
    check_value("t2_flush_ready", ld_ready, 0);
    @(negedge clk); #1;
    check_value("t2_done", load_done, 1);
    check_value("t2_m3fe", mem_model[10'h3FE], 32'hB0);
    check_value("t2_m3ff", mem_model[10'h3FF], 32'hB1);
    check_value("t2_m000", mem_model[10'h000], 32'hB2);
    check_value("t2_m001", mem_model[10'h001], 32'hB3);
    check_value("t2_m3fd", mem_model[10'h3FD], init_word(10'h3FD));
    check_value("t2_m002", mem_model[10'h002], init_word(2));
    $display("wrap load base=0x3FE len=4 with gaps done");

    // ---------------- fetch flags ----------------
    @(negedge clk); fetch_req = 1'b1; fetch_addr = 32'h0000_0006; #1;
    @(negedge clk); fetch_addr = 32'h0000_1000; #1;
    check_value("t3_mis_valid", fetch_valid, 1);
    check_value("t3_mis_flag", fetch_misaligned, 1);
    check_value("t3_mis_oor", fetch_oor, 0);
    check_value("t3_mis_data", fetch_data, 32'hB3);
    @(negedge clk); fetch_addr = 32'h0000_0FFC; #1;
    check_value("t3_oor_flag", fetch_oor, 1);
    check_value("t3_oor_mis", fetch_misaligned, 0);
    check_value("t3_oor_data", fetch_data, 0);
    @(negedge clk); fetch_addr = 32'h8000_0000; #1;
    check_value("t3_top_data", fetch_data, 32'hB1);
    check_value("t3_top_oor", fetch_oor, 0);
    @(negedge clk); fetch_req = 1'b0; #1;
    check_value("t3_hi_oor", fetch_oor, 1);
    check_value("t3_hi_data", fetch_data, 0);
    $display("fetch flag checks done");

    // ---------------- start+fetch same cycle, ignored restarts ----------------
    @(negedge clk); load_start = 1'b1; load_base = 10'h020; load_len = 11'd2;
    fetch_req = 1'b1; fetch_addr = 32'h48; #1;
    check_value("t4_ready_run", ld_ready, 0);
    @(negedge clk); load_base = 10'h100; load_len = 11'd5; fetch_addr = 32'h4C;
    ld_valid = 1'b1; ld_data = 32'hD0; #1;
    check_value("t4_fvalid", fetch_valid, 1);
    check_value("t4_fdata", fetch_data, 32'hA2);
    check_value("t4_ready", ld_ready, 1);
    check_value("t4_waddr0", mem_waddr, 10'h020);
    @(negedge clk); load_start = 1'b0; ld_data = 32'hD1; #1;
    check_value("t4_fetch_ignored", fetch_valid, 0);
    check_value("t4_fdata_hold", fetch_data, 32'hA2);
    check_value("t4_waddr1", mem_waddr, 10'h021);
    check_value("t4_we1", mem_we, 1);
    @(negedge clk); fetch_req = 1'b0; ld_valid = 1'b0; load_start = 1'b1; load_len = 11'd3; #1;
    check_value("t4_flush_ready", ld_ready, 0);
    check_value("t4_flush_busy", load_busy, 1);
    @(negedge clk); load_start = 1'b0; #1;
    check_value("t4_done", load_done, 1);
    check_value("t4_run_ready", ld_ready, 0);
    @(negedge clk); #1;
    check_value("t4_no_restart", load_busy, 0);
    check_value("t4_m020", mem_model[10'h020], 32'hD0);
    check_value("t4_m021", mem_model[10'h021], 32'hD1);
    check_value("t4_m100", mem_model[10'h100], init_word(10'h100));
    @(negedge clk); load_start = 1'b1; load_base = 10'h300; load_len = 11'd0; #1;
    check_value("t4_len0_stall_a", cpu_stall, 0);
    @(negedge clk); load_start = 1'b0; #1;
    check_value("t4_len0_stall", cpu_stall, 0);
    check_value("t4_len0_ready", ld_ready, 0);
    @(negedge clk); #1;
    check_value("t4_len0_done", load_done, 0);
    $display("same-cycle start/fetch, ignored restarts, zero-length load done");

    // ---------------- reset abort mid-load ----------------
    @(negedge clk); load_start = 1'b1; load_base = 10'h200; load_len = 11'd6; #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); load_start = 1'b0; ld_valid = 1'b1; ld_data = 32'hE0 + k; #1;
      check_value("t5_waddr", mem_waddr, 32'h200 + k);
    end
    @(negedge clk); ld_valid = 1'b0; #3; rst_n = 1'b0; #1;
    check_value("t5_rst_busy", load_busy, 0);
    check_value("t5_rst_stall", cpu_stall, 0);
    check_value("t5_rst_ready", ld_ready, 0);
    check_value("t5_rst_fdata", fetch_data, 0);
    check_value("t5_rst_done", load_done, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); ld_valid = 1'b1; ld_data = 32'hEE; #1;
    check_value("t5_run_we", mem_we, 0);
    check_value("t5_run_ready", ld_ready, 0);
    check_value("t5_run_done", load_done, 0);
    @(negedge clk); ld_valid = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h804; #1;
    check_value("t5_done_none", load_done, 0);
    @(negedge clk); fetch_req = 1'b0; #1;
    check_value("t5_fetch_e1", fetch_data, 32'hE1);
    check_value("t5_m200", mem_model[10'h200], 32'hE0);
    check_value("t5_m201", mem_model[10'h201], 32'hE1);
    check_value("t5_m202", mem_model[10'h202], init_word(10'h202));
    check_value("t5_m205", mem_model[10'h205], init_word(10'h205));
    $display("reset abort after 2 of 6 words done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/imem_load_controller.md
Name: imem_load_controller

Overview:
- Owns the single-port word-addressed instruction memory (1024 x 32, synchronous write, combinational read).
- Shares that memory between two requesters: the CPU fetch path, and a program loader that streams words in over a valid/ready handshake.
- While a load is in progress it stalls the CPU and blocks fetches.
- It registers fetch responses and flags misaligned or out-of-range PCs.

Parameters:
- ADDR_W, 10, word-address width (memory depth 2^ADDR_W words).
- DATA_W, 32, instruction/word width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  single-cycle pulse; begins a program load
- load_base  in  ADDR_W  first word address of load; sampled with load_start
- load_len  in  ADDR_W+1  word count, 0..2^ADDR_W; sampled with load_start
- ld_valid  in  1  loader word valid
- ld_data  in  DATA_W  loader word
- ld_ready  out  1  controller accepts loader word this cycle
- load_busy  out  1  high in LOAD and FLUSH states
- load_done  out  1  one-cycle pulse when a load completes
- cpu_stall  out  1  CPU must hold PC and not advance
- fetch_req  in  1  CPU fetch request
- fetch_addr  in  32  byte address from PC
- fetch_valid  out  1  registered fetch response valid
- fetch_data  out  DATA_W  registered instruction
- fetch_misaligned  out  1  qualifies fetch_valid; fetch_addr[1:0] != 0
- fetch_oor  out  1  qualifies fetch_valid; fetch_addr[31:ADDR_W+2] != 0
- mem_we  out  1  memory write enable
- mem_waddr  out  ADDR_W  memory write word address
- mem_wdata  out  DATA_W  memory write data
- mem_raddr  out  ADDR_W  memory read word address
- mem_rdata  in  DATA_W  memory read data, combinational from mem_raddr

Behaviour:
- Clock and reset: clk, rst_n; reset is asynchronous and active-low.
- Reset state:
  - state=RUN, word counter=0.
  - Outputs ld_ready, load_busy, load_done, cpu_stall, fetch_valid, fetch_misaligned, fetch_oor and mem_we are 0.
  - fetch_data=0, mem_waddr=0, mem_wdata=0.
- FSM states: RUN, LOAD, FLUSH.
- RUN, fetch servicing:
  - mem_raddr = fetch_addr[ADDR_W+1:2].
  - On fetch_req, fetch_valid=1 on the next cycle, with fetch_data = mem_rdata captured at the request edge.
  - Flags are registered alongside: fetch_misaligned = |fetch_addr[1:0]; fetch_oor = |fetch_addr[31:ADDR_W+2].
  - If fetch_oor=1, fetch_data=0. A misaligned fetch still returns the word at fetch_addr[ADDR_W+1:2].
  - Without fetch_req, fetch_valid=0 and fetch_data holds its last value.
- RUN -> LOAD:
  - Taken on load_start with load_len != 0; load_base and load_len are latched and counter=0.
  - load_start with load_len=0: no state change and no load_done.
  - load_start and fetch_req in the same cycle: the fetch is serviced normally, and LOAD begins the next cycle.
- LOAD:
  - ld_ready=1, cpu_stall=1, load_busy=1; fetch_req is ignored (fetch_valid=0).
  - Each ld_valid&&ld_ready cycle writes combinationally: mem_we=1, mem_waddr=(base+counter) mod 2^ADDR_W, mem_wdata=ld_data. The counter then increments.
  - The address wraps from 2^ADDR_W-1 to 0.
  - ld_valid low: no write and the counter holds. There is no timeout.
  - The handshake that accepts word load_len-1 moves the FSM to FLUSH.
  - load_start during LOAD or FLUSH is ignored.
- FLUSH:
  - Lasts 1 cycle, with ld_ready=0, cpu_stall=1, load_busy=1, no write.
  - The FSM then moves to RUN, and load_done=1 in the first RUN cycle only.
- cpu_stall deasserts in that same first RUN cycle, so a fetch issued then returns newly loaded data.
- Reset during LOAD or FLUSH:
  - Immediate abort; state=RUN; no load_done.
  - Words already written remain in memory.
- Arithmetic:
  - The counter is ADDR_W+1 bits wide, and completion compares it against load_len.
  - The address add is truncated to ADDR_W bits.

Test Plan:
- Reset with rst_n=0 mid-cycle -> all outputs 0 asynchronously; state RUN.
- load_start, base=0x010, len=4, ld_valid held high with data 0xA0..0xA3 -> writes to words 0x010..0x013 on 4 consecutive cycles; cpu_stall high for 5 cycles; load_done pulse 1 cycle after FLUSH; then fetch_addr=0x44 returns 0xA1 one cycle later.
- base=0x3FE, len=4, ld_valid toggling 1,0,1,0,... -> writes land at 0x3FE, 0x3FF, 0x000, 0x001 only on valid cycles; counter holds during gaps.
- Fetch 0x00000006 -> fetch_valid=1, fetch_misaligned=1, word 1 data. Fetch 0x00001000 -> fetch_oor=1, fetch_data=0.
- load_start with fetch_req in the same RUN cycle -> fetch answered next cycle; LOAD entered next cycle. A second load_start during LOAD has no effect. load_len=0 -> no stall, no load_done.
- rst_n asserted after 2 of 6 words -> immediate return to RUN, no load_done; the 2 written words are readable and the remaining words are unchanged.
